// File: rtl/seq_div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Signed operation is enabled with the SEQ_DIV_SIGNED_EN macro.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    always_comb begin
        w_shift = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_dvs};
        // A set top bit would mean the shifted value already exceeds the divisor
        w_ge    = i_rem[WIDTH] | (w_shift >= {1'b0, i_dvs});
        o_rem   = w_ge ? w_diff : w_shift;
        o_quo   = {i_quo[WIDTH-2:0], w_ge};
    end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready I/O.
// Define SEQ_DIV_SIGNED_EN to add the op_signed port for two's complement.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic             op_signed,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_zero;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_rem;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;

`ifdef SEQ_DIV_SIGNED_EN
    logic w_neg_a;
    logic w_neg_b;
    logic r_neg_q;
    logic r_neg_r;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem),
        .o_quo (w_quo)
    );

    // Magnitudes go into the datapath; signs are re-applied on DONE entry
    always_comb begin
        w_mag_a = dividend;
        w_mag_b = divisor;
        w_q_fin = w_quo;
        w_r_fin = w_rem[WIDTH-1:0];
`ifdef SEQ_DIV_SIGNED_EN
        w_neg_a = op_signed & dividend[WIDTH-1];
        w_neg_b = op_signed & divisor[WIDTH-1];
        if (w_neg_a) w_mag_a = -dividend;
        if (w_neg_b) w_mag_b = -divisor;
        if (r_neg_q) w_q_fin = -w_quo;
        if (r_neg_r) w_r_fin = -w_rem[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
`ifdef SEQ_DIV_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (divisor == '0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_div_zero  <= 1'b1;
                        end else begin
                            r_state <= BUSY;
                            r_rem   <= '0;
                            r_quo   <= w_mag_a;
                            r_dvs   <= w_mag_b;
                            r_cnt   <= '0;
`ifdef SEQ_DIV_SIGNED_EN
                            r_neg_q <= w_neg_a ^ w_neg_b;
                            r_neg_r <= w_neg_a;
`endif
                        end
                    end
                end
                BUSY: begin
                    r_rem <= w_rem;
                    r_quo <= w_quo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state     <= DONE;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_quotient  <= w_q_fin;
                        r_remainder <= w_r_fin;
                        r_div_zero  <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_div.sv
// Directed and randomised checks for seq_div at WIDTH=8.
// Signed vectors are exercised when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_div;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sg;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         op_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int n_checks = 0;
    int n_fail = 0;
    int n_hs = 0;
    int n_consumed = 0;

    always #5 clk = ~clk;

    seq_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef SEQ_DIV_SIGNED_EN
        .op_signed (op_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always @(posedge clk)
        if (rst_n && out_valid && out_ready) n_hs++;

    function automatic void chk(string name, logic [63:0] got,
                                logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge
    // where out_valid is first seen (or the bound expires).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sg, output int lat);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        op_signed = sg;
        @(negedge clk);
        in_valid  = 1'b0;
        dividend  = W'($urandom);
        divisor   = W'($urandom);
        op_signed = ~sg;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_consumed++;
    endtask

    vec_t vecs[$];
    int   lat;
    int   rises;
    logic [W-1:0] ea;
    logic [W-1:0] eb;

    initial begin
        vecs.push_back('{8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   1'b0});
        vecs.push_back('{8'd255, 8'd0,   1'b0, 8'd255, 8'd255, 1'b1});
        vecs.push_back('{8'd9,   8'd4,   1'b0, 8'd2,   8'd1,   1'b0});
        vecs.push_back('{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   1'b0});
        vecs.push_back('{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0});
        vecs.push_back('{8'd7,   8'd9,   1'b0, 8'd0,   8'd7,   1'b0});
        vecs.push_back('{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0});
        vecs.push_back('{8'd128, 8'd16,  1'b0, 8'd8,   8'd0,   1'b0});
        vecs.push_back('{8'd254, 8'd17,  1'b0, 8'd14,  8'd16,  1'b0});
        vecs.push_back('{8'd1,   8'd0,   1'b0, 8'd255, 8'd1,   1'b1});
`ifdef SEQ_DIV_SIGNED_EN
        vecs.push_back('{8'hF9, 8'd2,  1'b1, 8'hFD, 8'hFF, 1'b0});
        vecs.push_back('{8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0});
        vecs.push_back('{8'd7,  8'hFE, 1'b1, 8'hFD, 8'd1,  1'b0});
        vecs.push_back('{8'hF9, 8'd0,  1'b1, 8'hFF, 8'hF9, 1'b1});
        vecs.push_back('{8'hF9, 8'd2,  1'b0, 8'd124, 8'd1, 1'b0});
`endif

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            chk("vec_in_ready", 64'(in_ready), 64'd1);
            run_op(vecs[i].a, vecs[i].b, vecs[i].sg, lat);
            chk("vec_latency", 64'(lat), vecs[i].dz ? 64'd1 : 64'd9);
            chk("vec_quotient", 64'(quotient), 64'(vecs[i].q));
            chk("vec_remainder", 64'(remainder), 64'(vecs[i].r));
            chk("vec_div_zero", 64'(div_zero), 64'(vecs[i].dz));
            consume();
            chk("vec_idle", 64'(in_ready), 64'd1);
        end

        // Stall in DONE with a competing request that must be ignored
        run_op(8'd200, 8'd3, 1'b0, lat);
        chk("stall_latency", 64'(lat), 64'd9);
        in_valid = 1'b1;
        dividend = 8'd10;
        divisor  = 8'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_quotient", 64'(quotient), 64'd66);
            chk("stall_remainder", 64'(remainder), 64'd2);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_consumed++;
        chk("stall_idle", 64'(in_ready), 64'd1);
        chk("stall_out_clear", 64'(out_valid), 64'd0);
        chk("hold_quotient", 64'(quotient), 64'd66);
        chk("hold_remainder", 64'(remainder), 64'd2);

        // Reset in the middle of BUSY discards the operation
        in_valid = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_quotient", 64'(quotient), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        rises = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) rises++;
        end
        chk("midrst_no_result", 64'(rises), 64'd0);
        run_op(8'd9, 8'd4, 1'b0, lat);
        chk("post_rst_latency", 64'(lat), 64'd9);
        chk("post_rst_quotient", 64'(quotient), 64'd2);
        chk("post_rst_remainder", 64'(remainder), 64'd1);
        consume();

        // Back-to-back random operands against a reference model
        for (int n = 0; n < 2000; n++) begin
            ea = W'($urandom);
            eb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            run_op(ea, eb, 1'b0, lat);
            chk("rnd_latency", 64'(lat), (eb == 0) ? 64'd1 : 64'd9);
            chk("rnd_quotient", 64'(quotient),
                (eb == 0) ? 64'd255 : 64'(ea / eb));
            chk("rnd_remainder", 64'(remainder),
                (eb == 0) ? 64'(ea) : 64'(ea % eb));
            chk("rnd_div_zero", 64'(div_zero), 64'(eb == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("rnd_held_valid", 64'(out_valid), 64'd1);
            consume();
        end
        chk("handshake_count", 64'(n_hs), 64'(n_consumed));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
